// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy, threshold flags, sticky error flags, flush
// and a selectable standard / first-word-fall-through read port.
module sync_fifo_flags #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         err_clr,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             din,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_empty,
    output logic                         almost_full,
    output logic                         overflow,
    output logic                         underflow
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr_reg, rptr_reg;
    logic [CW-1:0]    count_reg;
    logic             overflow_reg, underflow_reg;
    logic             rd_acc, wr_acc, ovf_set, udf_set;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty        = (count_reg == '0);
    assign full         = (count_reg == CW'(DEPTH));
    assign almost_full  = (count_reg >= CW'(AF_LEVEL));
    assign almost_empty = (count_reg <= CW'(AE_LEVEL));
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    // Flush masks both requests, so it neither moves data nor raises errors.
    assign rd_acc  = rd_en && !empty && !flush;
    assign wr_acc  = wr_en && (!full || rd_acc) && !flush;
    assign ovf_set = wr_en && !wr_acc && !flush;
    assign udf_set = rd_en && empty && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            overflow_reg  <= (overflow_reg && !err_clr) || ovf_set;
            underflow_reg <= (underflow_reg && !err_clr) || udf_set;
            if (flush) begin
                wptr_reg  <= '0;
                rptr_reg  <= '0;
                count_reg <= '0;
            end else begin
                if (wr_acc) wptr_reg <= next_ptr(wptr_reg);
                if (rd_acc) rptr_reg <= next_ptr(rptr_reg);
                if (wr_acc && !rd_acc)      count_reg <= count_reg + CW'(1);
                else if (rd_acc && !wr_acc) count_reg <= count_reg - CW'(1);
            end
        end
    end

    // Storage carries no reset; a simultaneous read at full sees the old word.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wptr_reg] <= din;
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [WIDTH-1:0] dout_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)        dout_reg <= '0;
                else if (rd_acc) dout_reg <= mem[rptr_reg];
            end
            assign dout = dout_reg;
        end else begin : g_fwft
            assign dout = empty ? '0 : mem[rptr_reg];
        end
    endgenerate
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed checks of sync_fifo_flags: fill/drain, full/empty corner cases,
// non-power-of-two wrap, FWFT mode, flush/err_clr and asynchronous reset.
module tb_sync_fifo_flags;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // A: DEPTH=8 standard read
    logic a_flush = 0, a_err_clr = 0, a_wr = 0, a_rd = 0;
    logic [15:0] a_din = '0, a_dout;
    logic [3:0]  a_count;
    logic a_empty, a_full, a_ae, a_af, a_ovf, a_udf;
    // B: DEPTH=5 standard read
    logic b_flush = 0, b_err_clr = 0, b_wr = 0, b_rd = 0;
    logic [15:0] b_din = '0, b_dout;
    logic [2:0]  b_count;
    logic b_empty, b_full, b_ae, b_af, b_ovf, b_udf;
    // C: DEPTH=4 first-word-fall-through
    logic c_flush = 0, c_err_clr = 0, c_wr = 0, c_rd = 0;
    logic [15:0] c_din = '0, c_dout;
    logic [2:0]  c_count;
    logic c_empty, c_full, c_ae, c_af, c_ovf, c_udf;

    sync_fifo_flags #(.WIDTH(16), .DEPTH(8), .FWFT(0)) u_a (
        .clk(clk), .rst(rst), .flush(a_flush), .err_clr(a_err_clr),
        .wr_en(a_wr), .din(a_din), .rd_en(a_rd), .dout(a_dout), .count(a_count),
        .empty(a_empty), .full(a_full), .almost_empty(a_ae), .almost_full(a_af),
        .overflow(a_ovf), .underflow(a_udf));

    sync_fifo_flags #(.WIDTH(16), .DEPTH(5), .FWFT(0)) u_b (
        .clk(clk), .rst(rst), .flush(b_flush), .err_clr(b_err_clr),
        .wr_en(b_wr), .din(b_din), .rd_en(b_rd), .dout(b_dout), .count(b_count),
        .empty(b_empty), .full(b_full), .almost_empty(b_ae), .almost_full(b_af),
        .overflow(b_ovf), .underflow(b_udf));

    sync_fifo_flags #(.WIDTH(16), .DEPTH(4), .FWFT(1)) u_c (
        .clk(clk), .rst(rst), .flush(c_flush), .err_clr(c_err_clr),
        .wr_en(c_wr), .din(c_din), .rd_en(c_rd), .dout(c_dout), .count(c_count),
        .empty(c_empty), .full(c_full), .almost_empty(c_ae), .almost_full(c_af),
        .overflow(c_ovf), .underflow(c_udf));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] q[$];
        int mc, wi, ri;
        logic racc, wacc;

        // Reset values
        #2;
        chk("rst_count", a_count, 0);
        chk("rst_empty", a_empty, 1);
        chk("rst_full", a_full, 0);
        chk("rst_ae", a_ae, 1);
        chk("rst_af", a_af, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_udf", a_udf, 0);
        chk("rst_dout", a_dout, 0);
        chk("rst_c_dout", c_dout, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Fill A with 1..8
        for (int i = 1; i <= 8; i++) begin
            a_wr = 1; a_din = 16'(i);
            tick();
            $display("A write %0h count=%0d", i, a_count);
            chk("fill_count", a_count, i);
            chk("fill_af", a_af, (i >= 7));
            chk("fill_full", a_full, (i == 8));
            chk("fill_ae", a_ae, (i <= 1));
        end
        a_din = 16'h0009;
        tick();
        chk("ovf_count", a_count, 8);
        chk("ovf_flag", a_ovf, 1);
        a_wr = 0;

        // Drain 8
        for (int i = 1; i <= 8; i++) begin
            a_rd = 1;
            tick();
            $display("A read dout=%0h count=%0d", a_dout, a_count);
            chk("drain_dout", a_dout, i);
            chk("drain_count", a_count, 8 - i);
        end
        a_rd = 0;
        chk("drain_empty", a_empty, 1);
        chk("drain_udf", a_udf, 0);

        // Refill then simultaneous read/write at full
        for (int i = 0; i < 8; i++) begin
            a_wr = 1; a_din = 16'h0010 + 16'(i);
            tick();
        end
        chk("refill_full", a_full, 1);
        a_din = 16'hAAAA; a_rd = 1;
        tick();
        $display("A full rd+wr dout=%0h count=%0d", a_dout, a_count);
        chk("fullrw_count", a_count, 8);
        chk("fullrw_dout", a_dout, 16'h0010);
        chk("fullrw_full", a_full, 1);
        a_wr = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            $display("A read dout=%0h", a_dout);
            chk("fullrw_drain", a_dout, (i == 8) ? 16'hAAAA : 16'h0010 + 16'(i));
        end
        chk("fullrw_empty", a_empty, 1);

        // Simultaneous read/write when empty
        a_wr = 1; a_din = 16'h5555;
        tick();
        $display("A empty rd+wr count=%0d udf=%0b dout=%0h", a_count, a_udf, a_dout);
        chk("emptyrw_count", a_count, 1);
        chk("emptyrw_udf", a_udf, 1);
        chk("emptyrw_dout", a_dout, 16'hAAAA);
        a_wr = 0;
        tick();
        chk("emptyrw_read", a_dout, 16'h5555);
        chk("emptyrw_count0", a_count, 0);
        a_rd = 0;

        // Flush with wr_en at count 4, overflow still set
        for (int i = 0; i < 4; i++) begin
            a_wr = 1; a_din = 16'h0021 + 16'(i);
            tick();
        end
        chk("pre_flush_count", a_count, 4);
        chk("pre_flush_ovf", a_ovf, 1);
        a_flush = 1; a_din = 16'h0099;
        tick();
        $display("A flush count=%0d empty=%0b ovf=%0b", a_count, a_empty, a_ovf);
        a_flush = 0; a_wr = 0;
        chk("flush_count", a_count, 0);
        chk("flush_empty", a_empty, 1);
        chk("flush_ovf", a_ovf, 1);
        chk("flush_dout", a_dout, 16'h5555);

        // err_clr together with a new underflow keeps underflow set
        a_err_clr = 1; a_rd = 1;
        tick();
        chk("errclr_ovf", a_ovf, 0);
        chk("errclr_udf_hold", a_udf, 1);
        a_rd = 0;
        tick();
        a_err_clr = 0;
        chk("errclr_udf", a_udf, 0);

        // B: DEPTH=5 stream of 20 words with interleaved reads
        mc = 0; wi = 0; ri = 0;
        for (int cyc = 0; cyc < 100 && ri < 20; cyc++) begin
            racc = ((cyc % 2 == 1) || wi == 20) && (mc > 0);
            wacc = (wi < 20) && (cyc % 3 != 2) && (mc < 5 || racc);
            b_rd = racc; b_wr = wacc; b_din = 16'h0100 + 16'(wi);
            tick();
            if (racc) begin
                chk("b_dout", b_dout, q.pop_front());
                ri++;
            end
            if (wacc) begin
                q.push_back(16'h0100 + 16'(wi));
                wi++;
            end
            mc = mc + (wacc ? 1 : 0) - (racc ? 1 : 0);
            $display("B cyc=%0d wr=%0b rd=%0b count=%0d dout=%0h", cyc, wacc, racc, b_count, b_dout);
            chk("b_count", b_count, mc);
            chk("b_count_le5", (b_count <= 3'd5), 1);
        end
        b_rd = 0; b_wr = 0;
        chk("b_all_read", ri, 20);
        chk("b_no_ovf", b_ovf, 0);

        // C: FWFT
        c_wr = 1; c_din = 16'h1234;
        tick();
        c_wr = 0;
        $display("C write 1234 dout=%0h", c_dout);
        chk("c_fall_through", c_dout, 16'h1234);
        chk("c_not_empty", c_empty, 0);
        c_rd = 1;
        tick();
        c_rd = 0;
        chk("c_pop_dout", c_dout, 0);
        chk("c_pop_empty", c_empty, 1);
        c_wr = 1; c_din = 16'h1111;
        tick();
        c_din = 16'h2222;
        tick();
        c_wr = 0;
        chk("c_head", c_dout, 16'h1111);
        chk("c_count2", c_count, 2);
        c_rd = 1;
        tick();
        $display("C pop dout=%0h", c_dout);
        chk("c_next", c_dout, 16'h2222);
        tick();
        c_rd = 0;
        chk("c_last_pop", c_dout, 0);
        c_wr = 1; c_din = 16'h3333;
        tick();
        c_wr = 0; c_flush = 1;
        tick();
        c_flush = 0;
        chk("c_flush_dout", c_dout, 0);
        chk("c_flush_count", c_count, 0);

        // Asynchronous reset mid-stream at count 6
        for (int i = 0; i < 6; i++) begin
            a_wr = 1; a_din = 16'h0031 + 16'(i);
            tick();
        end
        a_wr = 0;
        chk("pre_arst_count", a_count, 6);
        #3 rst = 1'b0;
        #1;
        $display("A async reset count=%0d empty=%0b dout=%0h", a_count, a_empty, a_dout);
        chk("arst_count", a_count, 0);
        chk("arst_empty", a_empty, 1);
        chk("arst_dout", a_dout, 0);
        chk("arst_af", a_af, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        chk("post_arst_empty", a_empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
